lsq: RTL

//  In-order load/store queue between the execution stage and the data port. Buffers memory ops issued by
//  ex_stage, runs them one at a time on the dreq/drsp bus, and returns aligned, extended load data to the

---
 rtl/lsq.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq.sv
// lsq: in-order load/store queue issuing one memory op at a time on the dreq/drsp bus.
// Optional macro LSQ_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsq #(
  parameter int C_XLEN    = 32,
  parameter int C_DEPTH_X = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  output logic              ex_full_o,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  input  logic              dreqready_i,
  output logic              dreqvalid_o,
  output logic [1:0]        dreqhpl_o,
  output logic [C_XLEN-1:0] dreqaddr_o,
  output logic              dreqwr_o,
  output logic [3:0]        dreqbe_o,
  output logic [C_XLEN-1:0] dreqdata_o,
  output logic              drspready_o,
  input  logic              drspvalid_i,
  input  logic              drsprerr_i,
  input  logic              drspwerr_i,
  input  logic [C_XLEN-1:0] drspdata_i,
  output logic              ids_reg_wr_o,
  output logic [4:0]        ids_reg_addr_o,
  output logic [C_XLEN-1:0] ids_reg_data_o,
  output logic              hvec_err_o,
  output logic [1:0]        hvec_cause_o,
  output logic [C_XLEN-1:0] hvec_addr_o
);

  localparam int                   C_DEPTH   = 1 << C_DEPTH_X;
  localparam logic [C_DEPTH_X:0]   C_FULL    = (C_DEPTH_X+1)'(C_DEPTH);
  localparam logic [C_DEPTH_X:0]   C_CNT_ONE = (C_DEPTH_X+1)'(1'b1);
  localparam logic [C_DEPTH_X-1:0] C_PTR_ONE = C_DEPTH_X'(1'b1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2} state_t;

  // Access size: 0 byte, 1 half, 2 word; anything not a legal B/H encoding is a word.
  function automatic logic [1:0] f_size(input logic wr, input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      3'b000:  sz = 2'd0;
      3'b001:  sz = 2'd1;
      3'b100:  sz = wr ? 2'd2 : 2'd0;
      3'b101:  sz = wr ? 2'd2 : 2'd1;
      default: sz = 2'd2;
    endcase
    return sz;
  endfunction

  logic                 r_q_wr   [C_DEPTH];
  logic [2:0]           r_q_f3   [C_DEPTH];
  logic [4:0]           r_q_rd   [C_DEPTH];
  logic [C_XLEN-1:0]    r_q_data [C_DEPTH];
  logic [C_XLEN-1:0]    r_q_addr [C_DEPTH];
  logic [C_DEPTH_X-1:0] r_wptr, r_rptr;
  logic [C_DEPTH_X:0]   r_count, w_count_nx;
  state_t               r_state, w_state_nx;

  logic              r_full, r_dreqvalid, r_dreqwr, r_drspready, r_ids_wr, r_hvec_err;
  logic [3:0]        r_dreqbe;
  logic [4:0]        r_ids_addr;
  logic [1:0]        r_hvec_cause;
  logic [C_XLEN-1:0] r_dreqaddr, r_dreqdata, r_ids_data, r_hvec_addr;

  logic              w_push, w_pop, w_trap, w_go_req, w_req_ack, w_rsp_done, w_trap_pop;
  logic              w_h_wr;
  logic [2:0]        w_h_f3;
  logic [4:0]        w_h_rd;
  logic [1:0]        w_size;
  logic [3:0]        w_be;
  logic [C_XLEN-1:0] w_h_data, w_h_addr, w_eff, w_wdat, w_shift, w_ldat;

  assign w_h_wr   = r_q_wr[r_rptr];
  assign w_h_f3   = r_q_f3[r_rptr];
  assign w_h_rd   = r_q_rd[r_rptr];
  assign w_h_data = r_q_data[r_rptr];
  assign w_h_addr = r_q_addr[r_rptr];
  assign w_size   = f_size(w_h_wr, w_h_f3);
  assign w_push   = (ex_lq_wr_i || ex_sq_wr_i) && (r_count != C_FULL);

`ifdef LSQ_MISALIGN_TRAP_EN
  assign w_trap = ((w_size == 2'd1) && w_h_addr[0]) ||
                  ((w_size == 2'd2) && (w_h_addr[1:0] != 2'b00));
  assign w_eff  = w_h_addr;
`else
  assign w_trap = 1'b0;
  // Force natural alignment by clearing the low address bits.
  always_comb begin
    w_eff = w_h_addr;
    case (w_size)
      2'd1:    w_eff = {w_h_addr[C_XLEN-1:1], 1'b0};
      2'd2:    w_eff = {w_h_addr[C_XLEN-1:2], 2'b00};
      default: w_eff = w_h_addr;
    endcase
  end
`endif

  // Store byte enables and lane-replicated data; loads read the full word.
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = {C_XLEN{1'b0}};
    if (w_h_wr) begin
      case (w_size)
        2'd0:    begin w_be = 4'b0001 << w_eff[1:0]; w_wdat = {4{w_h_data[7:0]}}; end
        2'd1:    begin w_be = w_eff[1] ? 4'b1100 : 4'b0011; w_wdat = {2{w_h_data[15:0]}}; end
        default: begin w_be = 4'b1111; w_wdat = w_h_data; end
      endcase
    end else begin
      w_be   = 4'b1111;
      w_wdat = {C_XLEN{1'b0}};
    end
  end

  assign w_shift = drspdata_i >> {w_eff[1:0], 3'b000};

  // Load data extension: funct3[2] selects zero-extension for B/H.
  always_comb begin
    w_ldat = w_shift;
    case (w_size)
      2'd0:    w_ldat = w_h_f3[2] ? {{(C_XLEN-8){1'b0}}, w_shift[7:0]}
                                  : {{(C_XLEN-8){w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ldat = w_h_f3[2] ? {{(C_XLEN-16){1'b0}}, w_shift[15:0]}
                                  : {{(C_XLEN-16){w_shift[15]}}, w_shift[15:0]};
      default: w_ldat = w_shift;
    endcase
  end

  // FSM next state and one-cycle event flags.
  always_comb begin
    w_state_nx = r_state;
    w_go_req   = 1'b0;
    w_req_ack  = 1'b0;
    w_rsp_done = 1'b0;
    w_trap_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != {(C_DEPTH_X+1){1'b0}}) begin
          if (w_trap) begin
            w_trap_pop = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_go_req   = 1'b1;
            w_state_nx = S_REQ;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_REQ: begin
        if (dreqready_i) begin
          w_req_ack  = 1'b1;
          w_state_nx = S_RSP;
        end else begin
          w_state_nx = S_REQ;
        end
      end
      S_RSP: begin
        if (drspvalid_i) begin
          w_rsp_done = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_RSP;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_pop = w_trap_pop || w_rsp_done;

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + C_CNT_ONE;
      2'b01:   w_count_nx = r_count - C_CNT_ONE;
      default: w_count_nx = r_count;
    endcase
  end

  // Queue payload storage; contents are meaningless while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && w_push) begin
      r_q_wr[r_wptr]   <= ex_sq_wr_i;
      r_q_f3[r_wptr]   <= ex_funct3_i;
      r_q_rd[r_wptr]   <= ex_regd_addr_i;
      r_q_data[r_wptr] <= ex_regs2_data_i;
      r_q_addr[r_wptr] <= ex_addr_i;
    end
  end

  // Control state, bus request/response handshake and result strobes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_wptr       <= {C_DEPTH_X{1'b0}};
      r_rptr       <= {C_DEPTH_X{1'b0}};
      r_count      <= {(C_DEPTH_X+1){1'b0}};
      r_full       <= 1'b0;
      r_dreqvalid  <= 1'b0;
      r_dreqaddr   <= {C_XLEN{1'b0}};
      r_dreqwr     <= 1'b0;
      r_dreqbe     <= 4'b0000;
      r_dreqdata   <= {C_XLEN{1'b0}};
      r_drspready  <= 1'b0;
      r_ids_wr     <= 1'b0;
      r_ids_addr   <= 5'd0;
      r_ids_data   <= {C_XLEN{1'b0}};
      r_hvec_err   <= 1'b0;
      r_hvec_cause <= 2'd0;
      r_hvec_addr  <= {C_XLEN{1'b0}};
    end else if (clk_en_i) begin
      r_state    <= w_state_nx;
      r_count    <= w_count_nx;
      r_full     <= (w_count_nx == C_FULL);
      r_ids_wr   <= 1'b0;
      r_hvec_err <= 1'b0;
      if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
      if (w_trap_pop) begin
        r_hvec_err   <= 1'b1;
        r_hvec_cause <= w_h_wr ? 2'd3 : 2'd2;
        r_hvec_addr  <= w_h_addr;
      end
      if (w_go_req) begin
        r_dreqvalid <= 1'b1;
        r_dreqaddr  <= {w_eff[C_XLEN-1:2], 2'b00};
        r_dreqwr    <= w_h_wr;
        r_dreqbe    <= w_be;
        r_dreqdata  <= w_wdat;
      end
      if (w_req_ack) begin
        r_dreqvalid <= 1'b0;
        r_drspready <= 1'b1;
      end
      if (w_rsp_done) begin
        r_drspready <= 1'b0;
        if (w_h_wr ? drspwerr_i : drsprerr_i) begin
          r_hvec_err   <= 1'b1;
          r_hvec_cause <= w_h_wr ? 2'd1 : 2'd0;
          r_hvec_addr  <= w_h_addr;
        end else if (!w_h_wr && (w_h_rd != 5'd0)) begin
          r_ids_wr   <= 1'b1;
          r_ids_addr <= w_h_rd;
          r_ids_data <= w_ldat;
        end
      end
    end
  end

  assign ex_full_o      = r_full;
  assign dreqvalid_o    = r_dreqvalid;
  assign dreqhpl_o      = 2'b11;
  assign dreqaddr_o     = r_dreqaddr;
  assign dreqwr_o       = r_dreqwr;
  assign dreqbe_o       = r_dreqbe;
  assign dreqdata_o     = r_dreqdata;
  assign drspready_o    = r_drspready;
  assign ids_reg_wr_o   = r_ids_wr;
  assign ids_reg_addr_o = r_ids_addr;
  assign ids_reg_data_o = r_ids_data;
  assign hvec_err_o     = r_hvec_err;
  assign hvec_cause_o   = r_hvec_cause;
  assign hvec_addr_o    = r_hvec_addr;

endmodule
